dot_product_accumulator: RTL and testbench

Streaming accumulator directly downstream of the pipelined 16x16 Wallace multiplier. It consumes one 32-bit unsigned product per cycle, qualified by a valid/last side-band that the issuing logic delays to match the multiplier's 4-cycle latency. It sums a vector of products into a wide accumulator and presents each finished dot product on a registered valid/ready output with overflow and truncation status. Nothing can stall the multiplier, so the input side has no ready; lost results are flagged instead.

---
 rtl/dot_product_accumulator_if.sv | 38 +++
 rtl/dot_product_accumulator.sv | 156 +++++++++++++++
 tb/tb_dot_product_accumulator.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_accumulator_if.sv
// dot_product_accumulator_if
//   Groups the product input side-band and the result output handshake of
//   dot_product_accumulator.
//   master : the surrounding logic (issues products, consumes results)
//   slave  : the accumulator itself
//   prod_i / prod_valid_i / prod_last_i : one product beat per cycle, no ready
//   acc_o / acc_count_o / acc_ovf_o / acc_trunc_o : finished result fields
//   acc_valid_o / acc_ready_i : result handshake
//
// Handshake: a result transfers on every rising edge where acc_valid_o=1 and
// acc_ready_i=1. While acc_valid_o=1 and acc_ready_i=0 all result fields hold
// steady. acc_ready_i may be asserted at any time, including while
// acc_valid_o=0. The product side has no ready: beats can never be stalled.
interface dot_product_accumulator_if #(
   parameter int IN_W  = 32,
   parameter int ACC_W = 40,
   parameter int CNT_W = 9
);
   logic [IN_W-1:0]  prod_i;
   logic             prod_valid_i;
   logic             prod_last_i;
   logic [ACC_W-1:0] acc_o;
   logic [CNT_W-1:0] acc_count_o;
   logic             acc_ovf_o;
   logic             acc_trunc_o;
   logic             acc_valid_o;
   logic             acc_ready_i;

   modport master (
      output prod_i, prod_valid_i, prod_last_i, acc_ready_i,
      input  acc_o, acc_count_o, acc_ovf_o, acc_trunc_o, acc_valid_o
   );

   modport slave (
      input  prod_i, prod_valid_i, prod_last_i, acc_ready_i,
      output acc_o, acc_count_o, acc_ovf_o, acc_trunc_o, acc_valid_o
   );
endinterface

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Sums a stream of unsigned products into a wide accumulator and presents
//   each finished dot product on a registered valid/ready output register.
//   A vector ends on prod_last_i or is force-terminated at MAX_LEN beats.
//   A finished result that finds the output register occupied is discarded
//   and flagged on the sticky drop_o.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   clear_i  synchronous abort of the partial vector; also clears drop_o
//   bus      dot_product_accumulator_if.slave (product input, result output)
//   busy_o   partial vector in progress (FSM in ACCUM)
//   drop_o   sticky: a finished result was discarded
//   state_o  raw FSM state encoding (0=IDLE, 1=ACCUM)
module dot_product_accumulator #(
   parameter int IN_W    = 32,
   parameter int ACC_W   = 40,
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   dot_product_accumulator_if.slave   bus,
   output logic                       busy_o,
   output logic                       drop_o,
   output logic                       state_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] out_acc_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic             out_ovf_q;
   logic             out_trunc_q;
   logic             out_valid_q, out_valid_d;
   logic             drop_q, drop_d;

   logic             beat;
   logic             finish;
   logic             slot_free;
   logic             load;
   logic [ACC_W:0]   sum;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf_new;

   // Datapath shared by both FSM states: in IDLE acc_q/cnt_q/ovf_q are zero,
   // so the same sum serves as the first beat of a new vector.
   always_comb begin
      beat      = bus.prod_valid_i & ~clear_i;
      sum       = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.prod_i};
      cnt_inc   = cnt_q + CNT_W'(1);
      ovf_new   = ovf_q | sum[ACC_W];
      finish    = beat & (bus.prod_last_i | (cnt_inc == MAX_CNT));
      slot_free = ~out_valid_q | bus.acc_ready_i;
      load      = finish & slot_free;
   end

   // Accumulation FSM: next state and accumulator registers.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear_i) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else if (beat) begin
         if (finish) begin
            // The accumulator is released whether or not the result lands.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end else begin
            state_d = ACCUM;
            acc_d   = sum[ACC_W-1:0];
            cnt_d   = cnt_inc;
            ovf_d   = ovf_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Output register control: a finish reloads the slot in the same cycle a
   // consumer drains it, so valid stays high across back-to-back results.
   always_comb begin
      out_valid_d = out_valid_q;
      drop_d      = drop_q;
      if (load) begin
         out_valid_d = 1'b1;
      end else if (bus.acc_ready_i) begin
         out_valid_d = 1'b0;
      end
      if (clear_i) begin
         drop_d = 1'b0;
      end else if (finish && !slot_free) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_acc_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_trunc_q <= 1'b0;
         out_valid_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         if (load) begin
            out_acc_q   <= sum[ACC_W-1:0];
            out_cnt_q   <= cnt_inc;
            out_ovf_q   <= ovf_new;
            out_trunc_q <= ~bus.prod_last_i;
         end
         out_valid_q <= out_valid_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.acc_o       = out_acc_q;
   assign bus.acc_count_o = out_cnt_q;
   assign bus.acc_ovf_o   = out_ovf_q;
   assign bus.acc_trunc_o = out_trunc_q;
   assign bus.acc_valid_o = out_valid_q;
   assign busy_o          = (state_q == ACCUM);
   assign drop_o          = drop_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator
//   Three instances share one stimulus stream:
//     u0 : defaults (ACC_W=40, MAX_LEN=256)
//     u1 : ACC_W=33 (overflow)
//     u2 : MAX_LEN=4 (truncation)
//   A reference model per instance pushes expected results into a queue;
//   a negedge monitor pops and compares them when a result is consumed.
module tb_dot_product_accumulator;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic [31:0] prod = '0;
   logic        pvalid = 1'b0;
   logic        plast = 1'b0;
   logic        pclear = 1'b0;
   logic        acc_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   dot_product_accumulator_if #(.IN_W(32), .ACC_W(40), .CNT_W(9)) if0 ();
   dot_product_accumulator_if #(.IN_W(32), .ACC_W(33), .CNT_W(9)) if1 ();
   dot_product_accumulator_if #(.IN_W(32), .ACC_W(40), .CNT_W(3)) if2 ();

   logic busy0, drop0, st0, busy1, drop1, st1, busy2, drop2, st2;

   assign if0.prod_i = prod;  assign if0.prod_valid_i = pvalid;
   assign if0.prod_last_i = plast;  assign if0.acc_ready_i = acc_ready;
   assign if1.prod_i = prod;  assign if1.prod_valid_i = pvalid;
   assign if1.prod_last_i = plast;  assign if1.acc_ready_i = acc_ready;
   assign if2.prod_i = prod;  assign if2.prod_valid_i = pvalid;
   assign if2.prod_last_i = plast;  assign if2.acc_ready_i = acc_ready;

   dot_product_accumulator #(.IN_W(32), .ACC_W(40), .MAX_LEN(256)) u0 (
      .clk(clk), .rst_n(rst_n), .clear_i(pclear), .bus(if0.slave),
      .busy_o(busy0), .drop_o(drop0), .state_o(st0));
   dot_product_accumulator #(.IN_W(32), .ACC_W(33), .MAX_LEN(256)) u1 (
      .clk(clk), .rst_n(rst_n), .clear_i(pclear), .bus(if1.slave),
      .busy_o(busy1), .drop_o(drop1), .state_o(st1));
   dot_product_accumulator #(.IN_W(32), .ACC_W(40), .MAX_LEN(4)) u2 (
      .clk(clk), .rst_n(rst_n), .clear_i(pclear), .bus(if2.slave),
      .busy_o(busy2), .drop_o(drop2), .state_o(st2));

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [63:0] acc;
      logic [15:0] cnt;
      logic        ovf;
      logic        trunc;
   } res_t;

   res_t exp_q0[$];
   res_t exp_q1[$];
   res_t exp_q2[$];

   logic [63:0] m_acc[3];
   int          m_cnt[3];
   logic        m_ovf[3];
   logic        m_busy[3];
   logic        m_valid[3];
   logic        m_drop[3];

   function automatic int acc_w_of(input int k);
      return (k == 1) ? 33 : 40;
   endfunction

   function automatic int max_len_of(input int k);
      return (k == 2) ? 4 : 256;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int k, input res_t r);
      case (k)
         0: exp_q0.push_back(r);
         1: exp_q1.push_back(r);
         default: exp_q2.push_back(r);
      endcase
   endtask

   task automatic model_step(input int k);
      logic [63:0] sum;
      logic [63:0] mask;
      logic        ovf;
      logic        slot_free;
      res_t        r;
      mask      = (64'd1 << acc_w_of(k)) - 64'd1;
      slot_free = !m_valid[k] || acc_ready;
      if (m_valid[k] && acc_ready) m_valid[k] = 1'b0;
      if (pclear) begin
         m_acc[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_busy[k] = 1'b0;
         m_drop[k] = 1'b0;
      end else if (pvalid) begin
         sum = m_acc[k] + {32'd0, prod};
         ovf = m_ovf[k] | ((sum & ~mask) != 64'd0);
         if (plast || (m_cnt[k] + 1 == max_len_of(k))) begin
            r.acc = sum & mask;
            r.cnt = 16'(m_cnt[k] + 1);
            r.ovf = ovf;
            r.trunc = !plast;
            if (slot_free) begin
               push_exp(k, r);
               m_valid[k] = 1'b1;
            end else begin
               m_drop[k] = 1'b1;
            end
            m_acc[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_busy[k] = 1'b0;
         end else begin
            m_acc[k] = sum & mask;
            m_cnt[k] = m_cnt[k] + 1;
            m_ovf[k] = ovf;
            m_busy[k] = 1'b1;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_acc[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_drop[k] = 1'b0;
         end
         exp_q0.delete();
         exp_q1.delete();
         exp_q2.delete();
      end else begin
         for (int k = 0; k < 3; k++) model_step(k);
      end
   end

   task automatic sb_cycle(input int k, input logic v, input logic [63:0] a,
                           input logic [15:0] c, input logic o, input logic t,
                           input logic b, input logic d, input logic s);
      res_t e;
      logic have;
      check($sformatf("valid%0d", k), 64'(v), 64'(m_valid[k]));
      check($sformatf("busy%0d", k), 64'(b), 64'(m_busy[k]));
      check($sformatf("state%0d", k), 64'(s), 64'(m_busy[k]));
      check($sformatf("drop%0d", k), 64'(d), 64'(m_drop[k]));
      if (v && acc_ready) begin
         have = 1'b0;
         e = '0;
         case (k)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            checks++;
            failures++;
            $display("FAIL sb%0d: result %0h delivered, expected queue empty", k, a);
         end else begin
            check($sformatf("sb%0d_acc", k), a, e.acc);
            check($sformatf("sb%0d_cnt", k), 64'(c), 64'(e.cnt));
            check($sformatf("sb%0d_ovf", k), 64'(o), 64'(e.ovf));
            check($sformatf("sb%0d_trunc", k), 64'(t), 64'(e.trunc));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         sb_cycle(0, if0.acc_valid_o, 64'(if0.acc_o), 16'(if0.acc_count_o),
                  if0.acc_ovf_o, if0.acc_trunc_o, busy0, drop0, st0);
         sb_cycle(1, if1.acc_valid_o, 64'(if1.acc_o), 16'(if1.acc_count_o),
                  if1.acc_ovf_o, if1.acc_trunc_o, busy1, drop1, st1);
         sb_cycle(2, if2.acc_valid_o, 64'(if2.acc_o), 16'(if2.acc_count_o),
                  if2.acc_ovf_o, if2.acc_trunc_o, busy2, drop2, st2);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [31:0] p, input logic v, input logic l, input logic c);
      prod = p; pvalid = v; plast = l; pclear = c;
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          len;
      logic [31:0] val;
      logic [63:0] acc;
      int          cnt;
      logic        ovf;
      logic [63:0] acc33;
      logic        ovf33;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1,   32'h00000005, 64'h5,           1,   1'b0, 64'h5,          1'b0};
      tbl[1] = '{3,   32'h00000010, 64'h30,          3,   1'b0, 64'h30,         1'b0};
      tbl[2] = '{2,   32'hFFFFFFFF, 64'h1FFFFFFFE,   2,   1'b0, 64'h1FFFFFFFE,  1'b0};
      tbl[3] = '{4,   32'h00000000, 64'h0,           4,   1'b0, 64'h0,          1'b0};
      tbl[4] = '{3,   32'hFFFFFFFF, 64'h2FFFFFFFD,   3,   1'b0, 64'h0FFFFFFFD,  1'b1};
      tbl[5] = '{256, 32'hFFFE0001, 64'hFFFE000100,  256, 1'b0, 64'h1FE000100,  1'b1};
      tbl[6] = '{10,  32'h12345678, 64'hB60B60B0,    10,  1'b0, 64'hB60B60B0,   1'b0};

      // reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 0, 0, 0);
      check("idle_valid", 64'(if0.acc_valid_o), 64'd0);

      // reset mid-vector with a pending result
      acc_ready = 1'b0;
      drive(1, 1, 1, 0);
      check("pre_rst_valid", 64'(if0.acc_valid_o), 64'd1);
      drive(2, 1, 0, 0);
      check("pre_rst_busy", 64'(busy0), 64'd1);
      pvalid = 1'b0; plast = 1'b0; prod = '0;
      rst_n = 1'b0;
      #1;
      check("rst_acc", 64'(if0.acc_o), 64'd0);
      check("rst_cnt", 64'(if0.acc_count_o), 64'd0);
      check("rst_ovf", 64'(if0.acc_ovf_o), 64'd0);
      check("rst_trunc", 64'(if0.acc_trunc_o), 64'd0);
      check("rst_valid", 64'(if0.acc_valid_o), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_drop", 64'(drop0), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      acc_ready = 1'b1;
      drive(5, 1, 1, 0);
      check("post_rst_acc", 64'(if0.acc_o), 64'd5);
      check("post_rst_cnt", 64'(if0.acc_count_o), 64'd1);
      check("post_rst_valid", 64'(if0.acc_valid_o), 64'd1);
      check("post_rst_drop", 64'(drop0), 64'd0);

      // basic vector 3,4,0x10
      drive(3, 1, 0, 0);
      check("basic_busy1", 64'(busy0), 64'd1);
      drive(4, 1, 0, 0);
      check("basic_busy2", 64'(busy0), 64'd1);
      drive(32'h10, 1, 1, 0);
      check("basic_busy3", 64'(busy0), 64'd0);
      check("basic_valid", 64'(if0.acc_valid_o), 64'd1);
      check("basic_acc", 64'(if0.acc_o), 64'h17);
      check("basic_cnt", 64'(if0.acc_count_o), 64'd3);
      drive(0, 0, 0, 0);
      check("basic_valid_once", 64'(if0.acc_valid_o), 64'd0);

      // table-driven vectors
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < tbl[i].len; j++) drive(tbl[i].val, 1, (j == tbl[i].len - 1), 0);
         check($sformatf("tbl%0d_valid", i), 64'(if0.acc_valid_o), 64'd1);
         check($sformatf("tbl%0d_acc", i), 64'(if0.acc_o), tbl[i].acc);
         check($sformatf("tbl%0d_cnt", i), 64'(if0.acc_count_o), 64'(tbl[i].cnt));
         check($sformatf("tbl%0d_ovf", i), 64'(if0.acc_ovf_o), 64'(tbl[i].ovf));
         check($sformatf("tbl%0d_trunc", i), 64'(if0.acc_trunc_o), 64'd0);
         check($sformatf("tbl%0d_acc33", i), 64'(if1.acc_o), tbl[i].acc33);
         check($sformatf("tbl%0d_ovf33", i), 64'(if1.acc_ovf_o), 64'(tbl[i].ovf33));
         drive(0, 0, 0, 0);
      end

      // truncation on the MAX_LEN=4 instance
      for (int j = 0; j < 6; j++) begin
         drive(1, 1, (j == 5), 0);
         if (j == 3) begin
            check("trunc1_valid", 64'(if2.acc_valid_o), 64'd1);
            check("trunc1_acc", 64'(if2.acc_o), 64'd4);
            check("trunc1_cnt", 64'(if2.acc_count_o), 64'd4);
            check("trunc1_flag", 64'(if2.acc_trunc_o), 64'd1);
         end
      end
      check("trunc2_acc", 64'(if2.acc_o), 64'd2);
      check("trunc2_cnt", 64'(if2.acc_count_o), 64'd2);
      check("trunc2_flag", 64'(if2.acc_trunc_o), 64'd0);
      drive(0, 0, 0, 0);

      // backpressure and drop
      acc_ready = 1'b0;
      drive(7, 1, 1, 0);
      check("bp_first", 64'(if0.acc_o), 64'd7);
      drive(9, 1, 1, 0);
      check("bp_hold_acc", 64'(if0.acc_o), 64'd7);
      check("bp_drop", 64'(drop0), 64'd1);
      acc_ready = 1'b1;
      drive(2, 1, 1, 0);
      check("bp_reload_acc", 64'(if0.acc_o), 64'd2);
      check("bp_reload_valid", 64'(if0.acc_valid_o), 64'd1);

      // clear with concurrent beat
      drive(5, 1, 0, 0);
      drive(6, 1, 0, 0);
      drive(100, 1, 0, 1);
      check("clr_busy", 64'(busy0), 64'd0);
      check("clr_drop", 64'(drop0), 64'd0);
      drive(8, 1, 1, 0);
      check("clr_acc", 64'(if0.acc_o), 64'd8);
      check("clr_cnt", 64'(if0.acc_count_o), 64'd1);
      check("clr_valid", 64'(if0.acc_valid_o), 64'd1);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         acc_ready = ($urandom_range(0, 3) != 0);
         drive($urandom(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 40) == 0));
      end

      // drain
      acc_ready = 1'b1;
      repeat (3) drive(0, 0, 0, 0);
      check("drain_q0", 64'(exp_q0.size()), 64'd0);
      check("drain_q1", 64'(exp_q1.size()), 64'd0);
      check("drain_q2", 64'(exp_q2.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
